// File: rtl/uart_defines.sv
// Shared UART definitions: transmit FSM state encoding and frame constants.
package uart_defines;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } uart_tx_state_t;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_BIT_CNT_W = $clog2(UART_DATA_BITS);

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX byte FIFO with registered occupancy flags.
// Ports:
//   clk, rstn      : clock, async active-low reset (pointers and level cleared)
//   push, wdata    : write request and byte; ignored while full
//   pop            : read request; ignored while empty
//   rdata_c        : current head byte (combinational read of storage)
//   full, empty    : registered occupancy flags
//   level          : registered occupancy, 0..FIFO_DEPTH
module uart_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          push,
    input  logic                          pop,
    input  logic [7:0]                    wdata,
    output logic [7:0]                    rdata_c,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          push_ok;
    logic          pop_ok;

    // Flags come from registered state, so a push on full is rejected even if a pop lands in the same cycle.
    assign push_ok = push && !full_q;
    assign pop_ok  = pop && !empty_q;

    // Pointer and occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        full_d  = (level_d == LW'(FIFO_DEPTH));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata_c = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = level_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: buffers CPU bytes and sends them as 8N1 frames,
// advancing one bit per baud_tick.
// Ports:
//   clk, rstn      : clock, async active-low reset
//   baud_tick      : one-cycle pulse per bit period
//   wr_en, wr_data : byte push from the MMIO register
//   ovf_clr        : clears the sticky overflow flag
//   full, empty    : FIFO occupancy flags
//   level          : FIFO occupancy
//   busy           : frame in progress
//   ovf            : sticky, a write was dropped on a full FIFO
//   tx             : serial line, idle high
module uart_tx_ctrl
    import uart_defines::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          baud_tick,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          ovf_clr,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          ovf,
    output logic                          tx
);

    uart_tx_state_t              state_q, state_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic [UART_BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                        tx_q, tx_d;
    logic                        busy_q, busy_d;
    logic                        ovf_q, ovf_d;
    logic                        pop_c;
    logic [7:0]                  fifo_rdata_c;
    logic                        fifo_full;
    logic                        fifo_empty;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (wr_en),
        .pop     (pop_c),
        .wdata   (wr_data),
        .rdata_c (fifo_rdata_c),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // Frame FSM; every transition is gated by baud_tick.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        pop_c     = 1'b0;
        if (baud_tick) begin
            unique case (state_q)
                TX_IDLE: begin
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        shift_d = fifo_rdata_c;
                        tx_d    = 1'b0;
                        state_d = TX_START;
                    end else begin
                        tx_d    = 1'b1;
                    end
                end
                TX_START: begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = TX_DATA;
                end
                TX_DATA: begin
                    if (bit_cnt_q == UART_BIT_CNT_W'(UART_DATA_BITS - 1)) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + UART_BIT_CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        shift_d = fifo_rdata_c;
                        tx_d    = 1'b0;
                        state_d = TX_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = TX_IDLE;
                    end
                end
                default: begin
                    tx_d    = 1'b1;
                    state_d = TX_IDLE;
                end
            endcase
        end
        busy_d = (state_d != TX_IDLE);
    end

    // Sticky overflow; a dropped write beats a clear in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (wr_en && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= TX_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    assign full  = fifo_full;
    assign empty = fifo_empty;
    assign busy  = busy_q;
    assign ovf   = ovf_q;
    assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: stimulus queues expected line bits,
// a monitor compares tx at every bit period while a frame is in progress.
module tb_uart_tx_ctrl;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TICK_DIV = 8;

    logic       clk = 1'b0;
    logic       rstn;
    logic       baud_tick;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       ovf_clr;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       busy;
    logic       ovf;
    logic       tx;

    logic       tick_en;
    logic       tick_force;
    logic       gen_tick;
    logic       tick_s;

    int         n_checks;
    int         n_err;
    logic       exp_q[$];

    uart_tx_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .baud_tick (baud_tick),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .ovf_clr   (ovf_clr),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .busy      (busy),
        .ovf       (ovf),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    assign baud_tick = tick_en ? gen_tick : tick_force;

    // Free-running baud pulse, one clock in every TICK_DIV, changed on the falling edge.
    initial begin
        int gcnt;
        gcnt     = 0;
        gen_tick = 1'b0;
        forever begin
            @(negedge clk);
            gcnt++;
            gen_tick = ((gcnt % TICK_DIV) == 0);
        end
    end

    // Remember whether the last rising edge carried a tick.
    initial begin
        tick_s = 1'b0;
        forever begin
            @(posedge clk);
            tick_s = baud_tick;
        end
    end

    // Monitor: one line bit per tick while busy, compared against the scoreboard.
    initial begin
        logic e;
        forever begin
            @(negedge clk);
            if (rstn && tick_s && busy) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL tx_bit: got %0b, required no bit (nothing queued)", tx);
                end else begin
                    e = exp_q.pop_front();
                    if (tx !== e) begin
                        n_err++;
                        $display("FAIL tx_bit: got %0b, required %0b (%0d left)", tx, e, exp_q.size());
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_frame(input logic [7:0] b);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        exp_q.push_back(1'b1);
    endtask

    // Called at a falling edge; returns one falling edge later.
    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && empty) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, 32'(done), 32'd1);
    endtask

    initial begin
        int cnt;
        bit seen;
        n_checks   = 0;
        n_err      = 0;
        rstn       = 1'b0;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        ovf_clr    = 1'b0;
        tick_en    = 1'b0;
        tick_force = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx",    32'(tx),    32'd1);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf",   32'(ovf),   32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Single byte 0xA5
        expect_frame(8'hA5);
        push(8'hA5);
        chk("single_level", 32'(level), 32'd1);
        tick_en = 1'b1;
        drain("single_drain");
        chk("single_busy",  32'(busy),  32'd0);
        chk("single_empty", 32'(empty), 32'd1);
        chk("single_tx",    32'(tx),    32'd1);

        // Back to back 0x00, 0xFF with no idle bit between frames
        tick_en = 1'b0;
        expect_frame(8'h00);
        expect_frame(8'hFF);
        push(8'h00);
        push(8'hFF);
        chk("b2b_level2", 32'(level), 32'd2);
        tick_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1'b1;
                break;
            end
        end
        chk("b2b_start", 32'(seen), 32'd1);
        chk("b2b_level1", 32'(level), 32'd1);
        cnt = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tick_s) begin
                if (busy) cnt++;
                else break;
            end
        end
        chk("b2b_busy_bits", 32'(cnt),   32'd20);
        chk("b2b_level0",    32'(level), 32'd0);
        drain("b2b_drain");

        // Overflow: 17 pushes with ticks held low
        tick_en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) expect_frame(8'(i * 7 + 1));
            push(8'(i * 7 + 1));
        end
        chk("ovf_level", 32'(level), 32'd16);
        chk("ovf_full",  32'(full),  32'd1);
        chk("ovf_flag",  32'(ovf),   32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'd0);
        tick_en = 1'b1;
        drain("ovf_drain");

        // Push on full in the same cycle as a pop: write dropped
        tick_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            expect_frame(8'(8'hC3 ^ 8'(i)));
            push(8'(8'hC3 ^ 8'(i)));
        end
        chk("pf_full", 32'(full), 32'd1);
        tick_force = 1'b1;
        wr_en      = 1'b1;
        wr_data    = 8'hEE;
        @(negedge clk);
        tick_force = 1'b0;
        wr_en      = 1'b0;
        chk("pf_level", 32'(level), 32'd15);
        chk("pf_ovf",   32'(ovf),   32'd1);
        chk("pf_busy",  32'(busy),  32'd1);
        tick_en = 1'b1;
        drain("pf_drain");
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;

        // Reset idle: hold reset across 20 bit periods
        #2;
        rstn = 1'b0;
        #1;
        chk("ri_tx",    32'(tx),    32'd1);
        chk("ri_empty", 32'(empty), 32'd1);
        chk("ri_level", 32'(level), 32'd0);
        chk("ri_busy",  32'(busy),  32'd0);
        for (int i = 0; i < 20; i++) begin
            repeat (TICK_DIV) @(negedge clk);
            chk("ri_hold_tx", 32'(tx), 32'd1);
        end
        rstn = 1'b1;
        @(negedge clk);

        // Reset mid-frame during data bit 4 of 0x55; queued 0x12 is discarded
        tick_en = 1'b0;
        expect_frame(8'h55);
        push(8'h55);
        push(8'h12);
        tick_en = 1'b1;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tick_s && busy) cnt++;
            if (cnt == 6) break;
        end
        chk("rm_reach_bit4", 32'(cnt), 32'd6);
        chk("rm_level_pre",  32'(level), 32'd1);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        exp_q.delete();
        chk("rm_tx",    32'(tx),    32'd1);
        chk("rm_level", 32'(level), 32'd0);
        chk("rm_busy",  32'(busy),  32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        expect_frame(8'h3C);
        push(8'h3C);
        drain("rm_3c_drain");
        chk("rm_final_tx", 32'(tx), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
